// File: rtl/rr_mux_arbiter.sv
// Round-robin owner of the shared 4-way datapath mux: grants one requester at a time,
// caps each tenure at HOLD_MAX cycles and leaves one dead cycle between owners.
module rr_mux_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       i1,
    output logic       i2,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RECOVER
    } state_t;

    localparam logic [7:0] LIMIT = 8'(HOLD_MAX - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] sel;
    logic [1:0] sel_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       timeout_nxt;

    logic       found;
    logic [1:0] win;
    logic [1:0] scan;

    // First active request at or above ptr, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        scan  = ptr;
        for (int i = 0; i < 4; i++) begin
            scan = ptr + 2'(i);
            if (!found && req[scan]) begin
                found = 1'b1;
                win   = scan;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        sel_nxt     = sel;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        timeout_nxt = 1'b0;

        case (state)
            IDLE, RECOVER: begin
                gnt_nxt = 4'b0000;
                if (found) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 4'b0001 << win;
                    sel_nxt   = win;
                    cnt_nxt   = 8'd0;
                    ptr_nxt   = win + 2'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end

            // A voluntary drop wins over the limit, so no timeout on that edge.
            GRANT: begin
                if (!req[sel]) begin
                    state_nxt = RECOVER;
                    gnt_nxt   = 4'b0000;
                    cnt_nxt   = 8'd0;
                end else if (cnt == LIMIT) begin
                    state_nxt   = RECOVER;
                    gnt_nxt     = 4'b0000;
                    cnt_nxt     = 8'd0;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            sel     <= 2'b00;
            ptr     <= 2'b00;
            cnt     <= 8'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            sel     <= sel_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            busy    <= |gnt_nxt;
            timeout <= timeout_nxt;
        end
    end

    assign i1 = sel[0];
    assign i2 = sel[1];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Table-driven bench for rr_mux_arbiter at HOLD_MAX of 8, 4 and 1, with expectations
// queued at stimulus time and popped one edge later when the outputs are sampled.
module tb_rr_mux_arbiter;

    typedef struct {
        bit         fresh;
        int         dut;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       tmo;
        string      tag;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       tmo;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_d  [3];
    logic [3:0] gnt_d  [3];
    logic       i1_d   [3];
    logic       i2_d   [3];
    logic       busy_d [3];
    logic       tmo_d  [3];

    vec_t vecs[$];
    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.HOLD_MAX(8)) dut8 (
        .clk(clk), .rst(rst), .req(req_d[0]), .gnt(gnt_d[0]),
        .i1(i1_d[0]), .i2(i2_d[0]), .busy(busy_d[0]), .timeout(tmo_d[0])
    );

    rr_mux_arbiter #(.HOLD_MAX(4)) dut4 (
        .clk(clk), .rst(rst), .req(req_d[1]), .gnt(gnt_d[1]),
        .i1(i1_d[1]), .i2(i2_d[1]), .busy(busy_d[1]), .timeout(tmo_d[1])
    );

    rr_mux_arbiter #(.HOLD_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .req(req_d[2]), .gnt(gnt_d[2]),
        .i1(i1_d[2]), .i2(i2_d[2]), .busy(busy_d[2]), .timeout(tmo_d[2])
    );

    function automatic void addVec(bit fresh, int d, logic [3:0] r, logic [3:0] g,
                                   logic [1:0] s, logic t, string tag);
        vec_t v;
        v.fresh = fresh;
        v.dut   = d;
        v.req   = r;
        v.gnt   = g;
        v.sel   = s;
        v.tmo   = t;
        v.tag   = tag;
        vecs.push_back(v);
    endfunction

    function automatic void pushExp(logic [3:0] g, logic [1:0] s, logic t, string tag);
        exp_t e;
        e.gnt  = g;
        e.sel  = s;
        e.busy = |g;
        e.tmo  = t;
        e.tag  = tag;
        expq.push_back(e);
    endfunction

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 3; d++) req_d[d] = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        req_d[v.dut] = v.req;
        pushExp(v.gnt, v.sel, v.tmo, v.tag);
    endtask

    task automatic checkOutput(input int d);
        exp_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, required one pending expectation");
        end else begin
            e = expq.pop_front();
            if (gnt_d[d] !== e.gnt || {i2_d[d], i1_d[d]} !== e.sel ||
                busy_d[d] !== e.busy || tmo_d[d] !== e.tmo) begin
                errors++;
                $display("[TB] FAIL %s: got gnt=%b sel=%b busy=%b timeout=%b, required gnt=%b sel=%b busy=%b timeout=%b",
                         e.tag, gnt_d[d], {i2_d[d], i1_d[d]}, busy_d[d], tmo_d[d],
                         e.gnt, e.sel, e.busy, e.tmo);
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test, required completion within 100000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // HOLD_MAX=8, single requester, short hold
        addVec(1, 0, 4'b0100, 4'b0100, 2'b10, 0, "short_g1");
        addVec(0, 0, 4'b0100, 4'b0100, 2'b10, 0, "short_g2");
        addVec(0, 0, 4'b0100, 4'b0100, 2'b10, 0, "short_g3");
        addVec(0, 0, 4'b0000, 4'b0000, 2'b10, 0, "short_rel");
        addVec(0, 0, 4'b0000, 4'b0000, 2'b10, 0, "short_idle");
        // HOLD_MAX=8, fairness with each owner dropping after two cycles
        addVec(1, 0, 4'b1111, 4'b0001, 2'b00, 0, "rr_r0a");
        addVec(0, 0, 4'b1111, 4'b0001, 2'b00, 0, "rr_r0b");
        addVec(0, 0, 4'b1110, 4'b0000, 2'b00, 0, "rr_dead0");
        addVec(0, 0, 4'b1111, 4'b0010, 2'b01, 0, "rr_r1a");
        addVec(0, 0, 4'b1111, 4'b0010, 2'b01, 0, "rr_r1b");
        addVec(0, 0, 4'b1101, 4'b0000, 2'b01, 0, "rr_dead1");
        addVec(0, 0, 4'b1111, 4'b0100, 2'b10, 0, "rr_r2a");
        addVec(0, 0, 4'b1111, 4'b0100, 2'b10, 0, "rr_r2b");
        addVec(0, 0, 4'b1011, 4'b0000, 2'b10, 0, "rr_dead2");
        addVec(0, 0, 4'b1111, 4'b1000, 2'b11, 0, "rr_r3a");
        addVec(0, 0, 4'b1111, 4'b1000, 2'b11, 0, "rr_r3b");
        addVec(0, 0, 4'b0111, 4'b0000, 2'b11, 0, "rr_dead3");
        addVec(0, 0, 4'b1111, 4'b0001, 2'b00, 0, "rr_wrap0");
        // HOLD_MAX=4, lone requester hits the limit repeatedly
        for (int k = 0; k < 2; k++) begin
            addVec(k == 0, 1, 4'b1000, 4'b1000, 2'b11, 0, "tmo_g1");
            addVec(0, 1, 4'b1000, 4'b1000, 2'b11, 0, "tmo_g2");
            addVec(0, 1, 4'b1000, 4'b1000, 2'b11, 0, "tmo_g3");
            addVec(0, 1, 4'b1000, 4'b1000, 2'b11, 0, "tmo_g4");
            addVec(0, 1, 4'b1000, 4'b0000, 2'b11, 1, "tmo_dead");
        end
        addVec(0, 1, 4'b1000, 4'b1000, 2'b11, 0, "tmo_regrant");
        // HOLD_MAX=4, timed-out owner yields to the contender
        addVec(1, 1, 4'b0011, 4'b0001, 2'b00, 0, "cont_r0a");
        addVec(0, 1, 4'b0011, 4'b0001, 2'b00, 0, "cont_r0b");
        addVec(0, 1, 4'b0011, 4'b0001, 2'b00, 0, "cont_r0c");
        addVec(0, 1, 4'b0011, 4'b0001, 2'b00, 0, "cont_r0d");
        addVec(0, 1, 4'b0011, 4'b0000, 2'b00, 1, "cont_tmo0");
        addVec(0, 1, 4'b0011, 4'b0010, 2'b01, 0, "cont_r1a");
        addVec(0, 1, 4'b0011, 4'b0010, 2'b01, 0, "cont_r1b");
        addVec(0, 1, 4'b0011, 4'b0010, 2'b01, 0, "cont_r1c");
        addVec(0, 1, 4'b0011, 4'b0010, 2'b01, 0, "cont_r1d");
        addVec(0, 1, 4'b0011, 4'b0000, 2'b01, 1, "cont_tmo1");
        addVec(0, 1, 4'b0011, 4'b0001, 2'b00, 0, "cont_back0");
        // HOLD_MAX=4, owner drops on the limit edge: normal release
        addVec(1, 1, 4'b0100, 4'b0100, 2'b10, 0, "lim4_g1");
        addVec(0, 1, 4'b0100, 4'b0100, 2'b10, 0, "lim4_g2");
        addVec(0, 1, 4'b0100, 4'b0100, 2'b10, 0, "lim4_g3");
        addVec(0, 1, 4'b0100, 4'b0100, 2'b10, 0, "lim4_g4");
        addVec(0, 1, 4'b0000, 4'b0000, 2'b10, 0, "lim4_drop");
        addVec(0, 1, 4'b0000, 4'b0000, 2'b10, 0, "lim4_idle");
        // HOLD_MAX=1 toggling, then drop on the limit edge
        addVec(1, 2, 4'b0001, 4'b0001, 2'b00, 0, "h1_g1");
        addVec(0, 2, 4'b0001, 4'b0000, 2'b00, 1, "h1_tmo1");
        addVec(0, 2, 4'b0001, 4'b0001, 2'b00, 0, "h1_g2");
        addVec(0, 2, 4'b0001, 4'b0000, 2'b00, 1, "h1_tmo2");
        addVec(0, 2, 4'b0001, 4'b0001, 2'b00, 0, "h1_g3");
        addVec(0, 2, 4'b0000, 4'b0000, 2'b00, 0, "h1_drop");
        addVec(0, 2, 4'b0000, 4'b0000, 2'b00, 0, "h1_idle");

        rst = 1'b1;
        for (int d = 0; d < 3; d++) req_d[d] = 4'b0000;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            pushExp(4'b0000, 2'b00, 0, "reset_state");
            checkOutput(d);
        end
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].fresh) doReset();
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(vecs[i].dut);
        end

        // Asynchronous reset in the middle of a grant
        doReset();
        @(negedge clk);
        req_d[0] = 4'b0010;
        pushExp(4'b0010, 2'b01, 0, "midrst_grant");
        @(posedge clk);
        #1;
        checkOutput(0);
        #2;
        rst = 1'b1;
        #1;
        pushExp(4'b0000, 2'b00, 0, "midrst_async");
        checkOutput(0);
        @(negedge clk);
        rst = 1'b0;
        req_d[0] = 4'b0001;
        pushExp(4'b0001, 2'b00, 0, "midrst_after");
        @(posedge clk);
        #1;
        checkOutput(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter and sequencer that shares the 4-way, 4-bit datapath multiplexer among four requesters. It owns the multiplexer's two select lines. It grants one requester at a time and bounds how long any requester may hold the mux. It inserts one dead cycle between owners so the shared bus never switches source mid-transfer. It sits beside the multiplexer in the multicycle datapath, with requests coming from the control/sequencing logic.

## Interface
- HOLD_MAX, 8: maximum consecutive cycles a grant may stay asserted; legal range 1..255.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-requester level request; bit k = requester k. Held high while mux is needed.
- gnt  output 4  registered one-hot grant; at most one bit high.
- i1   output 1  mux select LSB; drives the multiplexer's i1.
- i2   output 1  mux select MSB; drives the multiplexer's i2. The pair {i2,i1} is the binary index of the owner.
- busy output 1  high while any gnt bit is high.
- timeout output 1  single-cycle pulse when a grant is revoked by the HOLD_MAX limit.

## Operation
- Three states:
  - IDLE: no owner.
  - GRANT: owner holds the mux.
  - RECOVER: one dead cycle after every release.
- Arbitration is evaluated in IDLE and RECOVER on each rising edge.
  - Winner: the first set bit of req, scanning upward (mod 4) from priority pointer ptr.
  - On a win: state→GRANT, gnt[w]←1, {i2,i1}←w, hold counter←0, ptr←(w+1) mod 4.
  - No req: IDLE stays IDLE; RECOVER→IDLE.
- GRANT, on each edge:
  - req[owner]=0 → normal release.
  - Otherwise, counter==HOLD_MAX-1 → forced release, and timeout=1 for the next cycle.
  - Otherwise counter←counter+1.
- Release: gnt←0, state→RECOVER. {i2,i1} keeps the last owner's index (select is stable while idle).
- A requester cut off by timeout that still holds req competes normally from RECOVER. Since ptr has already rotated past it, every other active requester is served first.
- Requests from non-owners during GRANT are ignored (no preemption).
- Reset (asynchronous, any state including mid-grant): state=IDLE, gnt=0000, i1=0, i2=0, busy=0, timeout=0, ptr=0, counter=0.
- Counter width is 8 bits and never exceeds HOLD_MAX-1.

## Timing
- Grant latency: req sampled at edge E in IDLE/RECOVER → gnt and select valid after E, i.e. 1 cycle.
- Select lines change only on the same edge that asserts a new gnt; never while gnt is high.
- Grant duration: gnt high for exactly HOLD_MAX cycles if the owner never drops req.
- If the owner drops req after n < HOLD_MAX high cycles, gnt falls on the first edge sampling req low.
- Every release is followed by exactly one cycle with gnt=0000 (RECOVER) before any new grant.
- Back-to-back owners are therefore spaced one dead cycle apart.
- Owner drops req on the same edge the counter reaches HOLD_MAX-1: treated as normal release, timeout stays 0.
- busy is the OR of gnt, registered with it; no combinational path from req to any output.
- timeout is high exactly one cycle, coincident with the first RECOVER cycle.

## Test plan
- Reset mid-grant: req=0010 granted, assert rst asynchronously between edges → gnt=0000, {i2,i1}=00, busy=0 immediately. After rst release, req=0001 → gnt=0001 one edge later.
- Single requester, short hold: req=0100 for 3 cycles then 0000 → gnt=0100 and {i2,i1}=10 for 3 cycles, then gnt=0000, timeout never pulses.
- Round-robin fairness: req=1111 held, each requester drops req after 2 granted cycles then re-raises. Grant order must be 0,1,2,3,0 with one dead cycle between each.
- Timeout: HOLD_MAX=4, req=1000 held constantly → gnt=1000 for exactly 4 cycles, timeout=1 in the dead cycle. gnt=1000 reasserts the following cycle and the 4-on/1-off pattern repeats.
- Timeout with contender: HOLD_MAX=4, req=0011 held, requester 0 granted first → after 4 cycles and one dead cycle, requester 1 is granted ({i2,i1}=01), not requester 0.
- Boundary: HOLD_MAX=1 with req=0001 held → gnt toggles high/low every cycle and timeout pulses on every low cycle. Owner drop on the limit edge gives timeout=0.
